time_entry_ctrl: RTL
====================

TIME_ENTRY_CTRL -- requirements
Module: time_entry_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 3, meaning the number of BCD digits entered (legal 2..4; digit 0 = seconds ones, digit 1 = seconds tens, digit 2 = minutes ones, digit 3 = minutes tens).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port clearn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port key_valid  input  1  one-cycle strobe; key_digit is valid.
REQ-005 SHALL have port key_digit  input  4  keypad digit, BCD.
REQ-006 SHALL have port clear_key  input  1  one-cycle strobe; clear entry or abort.
REQ-007 SHALL have port start_key  input  1  one-cycle strobe; start or resume.
REQ-008 SHALL have port stop_key  input  1  one-cycle strobe; pause.
REQ-009 SHALL have port timer_done  input  1  high when the downstream mod-10/mod-6 counter chain has reached zero.
REQ-010 SHALL have port data  output  4*NUM_DIGITS  BCD preset value for the counter chain.
REQ-011 SHALL have port load  output  1  active-low parallel-load command to the counter chain.
REQ-012 SHALL have port en  output  1  count enable to the counter chain.
REQ-013 SHALL have port done  output  1  cooking-complete indication.
REQ-014 SHALL have port busy  output  1  high in RUN or PAUSED.

Function
REQ-015 SHALL implement states IDLE, ENTRY, LOAD, RUN, PAUSED, DONE; all outputs registered.
REQ-016 SHALL, in IDLE or ENTRY, on key_valid with key_digit <= 9, shift data left by 4 bits, insert key_digit in digit 0, increment an internal digit counter, and go to (or stay in) ENTRY.
REQ-017 SHALL ignore key_valid when key_digit > 9 (no shift, no count).
REQ-018 SHALL ignore key_valid once NUM_DIGITS digits are held; data unchanged (no wrap, no overwrite).
REQ-019 SHALL ignore key_valid in LOAD, RUN, PAUSED and DONE.
REQ-020 SHALL, on start_key in ENTRY with data nonzero, clamp digit 1 to 5 if > 5, clamp digit 3 (NUM_DIGITS = 4) to 5 if > 5, and go to LOAD.
REQ-021 SHALL ignore start_key in IDLE, and in ENTRY when data is all zeros.
REQ-022 SHALL drive load = 0 for exactly the one cycle spent in LOAD, with data stable and en = 0, then go unconditionally to RUN.
REQ-023 SHALL hold en = 1 in RUN only; en = 0 in all other states.
REQ-024 SHALL, in RUN, on timer_done = 1, go to DONE; timer_done is ignored in every other state.
REQ-025 SHALL, in RUN, on stop_key, go to PAUSED; on start_key in PAUSED, return to RUN with no reload (load stays 1).
REQ-026 SHALL, on clear_key in ENTRY, RUN, PAUSED or DONE, zero data and the digit counter and go to IDLE; clear_key in LOAD takes effect on the following cycle.
REQ-027 SHALL, in DONE, hold done = 1 and data unchanged; start_key in DONE also returns to IDLE with data zeroed.
REQ-028 SHALL resolve simultaneous strobes with priority clear_key > timer_done > start_key > stop_key > key_valid; lower-priority strobes in the same cycle are dropped.
REQ-029 SHALL produce load = 0 for exactly one cycle per accepted start from ENTRY, and never from any other path.

Reset
REQ-030 SHALL, on clearn = 0, immediately and asynchronously force state IDLE, data = 0, digit counter = 0, load = 1, en = 0, done = 0, busy = 0, regardless of state (including mid-RUN or mid-LOAD).
REQ-031 SHALL leave reset state on the first rising clk edge after clearn returns to 1, with no spurious load pulse.

Verification
REQ-032 SHALL verify with NUM_DIGITS = 3: digits 1, 3, 0, then start -> data = 12'h130, load low one cycle, next cycle en = 1, busy = 1.
REQ-033 SHALL verify: digits 1, 9, 5, then start -> data = 12'h155 (seconds tens clamped); digits 9, 9, 9, 7 -> 4th digit ignored, data = 12'h999; key_digit = 4'hC -> ignored.
REQ-034 SHALL verify: RUN, then stop_key -> PAUSED, en = 0; start_key -> RUN, en = 1, load remains 1 throughout.
REQ-035 SHALL verify: RUN, timer_done = 1 together with stop_key -> DONE, done = 1, en = 0; then clear_key -> IDLE, data = 0, done = 0.
REQ-036 SHALL verify: start_key in IDLE and after entering only 0, 0 -> no load pulse, state unchanged.
REQ-037 SHALL verify: clearn pulsed low asynchronously mid-RUN (between clk edges) -> en = 0, data = 0, busy = 0 before the next edge; no load pulse after release.

Source files
------------

// File: rtl/time_entry_ctrl.sv
// Keypad time-entry controller for a microwave-style countdown.
// Collects BCD digits, clamps tens-of-seconds/minutes to 5 on start,
// issues a one-cycle active-low load to the counter chain, then manages
// run/pause/done. All outputs are registered from the next state.
module time_entry_ctrl #(
  parameter int unsigned NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    clearn,
  input  logic                    key_valid,
  input  logic [3:0]              key_digit,
  input  logic                    clear_key,
  input  logic                    start_key,
  input  logic                    stop_key,
  input  logic                    timer_done,
  output logic [4*NUM_DIGITS-1:0] data,
  output logic                    load,
  output logic                    en,
  output logic                    done,
  output logic                    busy
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam logic [2:0]  MAX_CNT = 3'(NUM_DIGITS);

  typedef enum logic [2:0] {
    IDLE, ENTRY, LOAD, RUN, PAUSED, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            clr_pend_q, clr_pend_d;
  logic            load_q, load_d;
  logic            en_q, en_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            clr;

  assign data = data_q;
  assign load = load_q;
  assign en   = en_q;
  assign done = done_q;
  assign busy = busy_q;

  // Next-state and registered-output decode; strobe priority is
  // clear > timer_done > start > stop > key_valid.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    clr_pend_d = 1'b0;
    // A clear seen during the single LOAD cycle is carried into the next one.
    clr        = clear_key | clr_pend_q;

    unique case (state_q)
      IDLE, ENTRY: begin
        if (clr) begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
        end else if (start_key && state_q == ENTRY && data_q != '0) begin
          // Odd digits are the tens positions (seconds, minutes): max 5.
          for (int unsigned i = 1; i < NUM_DIGITS; i += 2) begin
            if (data_q[4*i +: 4] > 4'd5) data_d[4*i +: 4] = 4'd5;
          end
          state_d = LOAD;
        end else if (key_valid && key_digit <= 4'd9 && cnt_q < MAX_CNT) begin
          data_d  = {data_q[DW-5:0], key_digit};
          cnt_d   = cnt_q + 3'd1;
          state_d = ENTRY;
        end
      end
      LOAD: begin
        state_d    = RUN;
        clr_pend_d = clear_key;
      end
      RUN: begin
        if (clr) begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
        end else if (timer_done) begin
          state_d = DONE;
        end else if (stop_key) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (clr) begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
        end else if (start_key) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (clr || start_key) begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = '0;
        cnt_d   = '0;
      end
    endcase

    load_d = (state_d != LOAD);
    en_d   = (state_d == RUN);
    done_d = (state_d == DONE);
    busy_d = (state_d == RUN) || (state_d == PAUSED);
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q    <= IDLE;
      data_q     <= '0;
      cnt_q      <= '0;
      clr_pend_q <= 1'b0;
      load_q     <= 1'b1;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      clr_pend_q <= clr_pend_d;
      load_q     <= load_d;
      en_q       <= en_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

endmodule
